arb8_grant_ctrl: RTL
====================

# arb8_grant_ctrl

Eight-requester arbiter that shares one downstream resource using the team's 8-to-3 priority-encoding rule: the highest requesting index wins. It registers the winner and holds the grant until the owner releases or a hold timeout expires. It then inserts one idle gap cycle before re-arbitrating. It sits between eight request sources and the shared resource, and drives both a one-hot grant and a binary grant index.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles a grant may be held; 0 disables the timeout.
- `clk`  in  1  single clock, all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  8  request vector; bit i is requester i; level-sensitive.
- `gnt`  out  8  one-hot grant, registered; all zeros when no grant.
- `gnt_id`  out  3  binary index of the current or most recent grantee, registered.
- `gnt_valid`  out  1  high while a grant is held; equals `|gnt`.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- States:
  - IDLE: no grant held; arbitrates every cycle.
  - GRANT: one requester owns the resource.
  - GAP: one mandatory dead cycle after any release.
- IDLE:
  - If `req != 0`, select the winner by the priority rule. Load `gnt` = 1<<winner, `gnt_id` = winner, `gnt_valid` = 1, and clear the hold counter. Go to GRANT.
  - If `req == 0`, stay in IDLE with outputs unchanged. `gnt_id` keeps its last value.
- GRANT:
  - The hold counter increments each cycle, saturating at `MAX_HOLD`.
  - If `req[gnt_id] == 0`, release: clear `gnt` and `gnt_valid`, then go to GAP.
  - Else, if `MAX_HOLD != 0` and the counter reaches `MAX_HOLD`-1, force a release. This means the grant is never held longer than `MAX_HOLD` cycles. Clear `gnt` and `gnt_valid`, pulse `timeout` for one cycle, and go to GAP.
  - Requests from other indices are ignored, so there is no preemption.
- GAP: all grant outputs stay low for exactly one cycle, then go to IDLE unconditionally.
- Priority rule without the macro: fixed priority, index 7 highest and index 0 lowest, with no other input considered.
- Counter width is $clog2(MAX_HOLD+1), minimum 1 bit.
- Reset values: state IDLE, `gnt` 8'h00, `gnt_id` 3'd0, `gnt_valid` 0, `timeout` 0, hold counter 0, round-robin pointer 3'd0.
- Reset mid-grant: all outputs clear immediately (asynchronously), and arbitration resumes from IDLE after `rst_n` rises.

## Timing
- Grant latency: with `req` sampled nonzero in IDLE at edge N, `gnt` is visible after edge N.
- Release latency: with owner `req` low at edge M, `gnt` is low after edge M. The next grant is visible after edge M+2, with no earlier grant possible.
- Timeout: a grant asserted after edge N is revoked after edge N+`MAX_HOLD`. `timeout` is high in the same cycle in which `gnt` first reads zero.
- Back-to-back: minimum period between grants to different requesters is grant cycles plus one GAP cycle plus one IDLE cycle.
- Simultaneous release and timeout in the same cycle is treated as a normal release, with no `timeout` pulse.
- `req` changes inside GAP have no effect until IDLE.

## Configuration
- `ARB_RR_EN` defined: round-robin priority.
  - Pointer `last` = `gnt_id` of the most recent grant, loaded on each grant.
  - Search order is `last`-1, `last`-2, … wrapping down to `last`, modulo 8. The first requesting index in that order wins.
  - At reset `last` = 0, so the first search starts at 7; this is identical to fixed priority.
- `ARB_RR_EN` undefined: fixed priority as above, and no pointer register is built.

## Test plan
- Reset, then `req`=8'b0010_0110 held → `gnt`=8'b0010_0000, `gnt_id`=5, `gnt_valid`=1 one edge after sampling.
- Requester 5 drops `req` while bit 2 and bit 1 stay high → `gnt`=0 for one GAP cycle and one IDLE cycle, then `gnt`=8'b0000_0100 (fixed priority), `gnt_id`=2.
- `MAX_HOLD`=4, `req`=8'h80 held constantly → grant for exactly 4 cycles, `timeout` pulse with `gnt`=0, one gap, then re-grant to 7.
- `ARB_RR_EN` defined, `req`=8'hFF held with `MAX_HOLD`=2 → `gnt_id` sequence 7,6,5,4,3,2,1,0,7.
- Assert `rst_n`=0 mid-grant → `gnt`=0, `gnt_valid`=0, `gnt_id`=0 without waiting for a clock edge. After release with `req`=8'h01, `gnt_id`=0 and `gnt`=8'h01.
- `req`=0 for 10 cycles → `gnt_valid` stays 0, `timeout` stays 0, and the state remains IDLE.

Source files
------------

// File: rtl/arb8_grant_ctrl.sv
// Eight-requester arbiter: registered one-hot grant with hold timeout and one gap cycle.
// Define ARB_RR_EN for round-robin priority; otherwise index 7 always wins.
module arb8_grant_ctrl #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned CntW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CntW-1:0] HoldMax  = CntW'(MAX_HOLD);
  localparam logic [CntW-1:0] HoldLast = CntW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [7:0]      gnt_q, gnt_d;
  logic [2:0]      id_q, id_d;
  logic [CntW-1:0] hold_q, hold_d;
  logic            timeout_q, timeout_d;
  logic [2:0]      win_id;

`ifdef ARB_RR_EN
  logic [2:0] last_q, last_d;

  // Later iterations override earlier ones, so last-1 ends up with top priority.
  always_comb begin
    win_id = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (req[3'(last_q - 3'(k))]) win_id = 3'(last_q - 3'(k));
    end
  end
`else
  // Highest requesting index wins because it is assigned last.
  always_comb begin
    win_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) win_id = 3'(i);
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
`ifdef ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = 8'(1) << win_id;
          id_d    = win_id;
          hold_d  = '0;
          state_d = StGrant;
`ifdef ARB_RR_EN
          last_d  = win_id;
`endif
        end
      end
      StGrant: begin
        hold_d = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
        // An owner release takes precedence over a coincident timeout.
        if (!req[id_q]) begin
          gnt_d   = 8'h00;
          state_d = StGap;
        end else if ((MAX_HOLD != 0) && (hold_q == HoldLast)) begin
          gnt_d     = 8'h00;
          timeout_d = 1'b1;
          state_d   = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        gnt_d   = 8'h00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= 8'h00;
      id_q      <= 3'd0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 3'd0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule
